// File: rtl/logic_acc_pkg.sv
// logic_acc shared types: op codes, FSM states
// and the completed-operation counter width.
package logic_acc_pkg;

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RESULT = 1'b1
  } state_e;

  localparam int OPS_W = 4;

endpackage

// File: rtl/logic_acc_unit.sv
// logic_acc combinational op unit: y = f(a, b, op).
// The XOR path is built from one xor_gate per bit.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

module logic_unit
  import logic_acc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] x;

  for (genvar i = 0; i < WIDTH; i++) begin : g_xor
    xor_gate u_xor (
      .a (a[i]),
      .b (b[i]),
      .y (x[i])
    );
  end

  // select the bitwise result for the op code
  always_comb begin
    y = b;
    unique case (op_e'(op))
      OP_XOR:  y = x;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_LOAD: y = b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/logic_acc.sv
// logic_acc: bitwise accumulator with valid/ready
// handshake. Parity: define LOGIC_ACC_PARITY_EN.
module logic_acc
  import logic_acc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_zero,
  output logic             out_parity,
  output logic [OPS_W-1:0] ops_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [OPS_W-1:0] ops_q, ops_d;
  logic [WIDTH-1:0] op_y;

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .a  (acc_q),
    .b  (in_data),
    .op (in_op),
    .y  (op_y)
  );

  // next state: clear beats accept and release
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ops_d   = ops_q;
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_d   = op_y;
            state_d = S_RESULT;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            ops_d   = ops_q + 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state, accumulator and op counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ops_q   <= ops_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESULT);
  assign out_acc   = acc_q;
  assign out_zero  = (acc_q == '0);
  assign ops_done  = ops_q;

`ifdef LOGIC_ACC_PARITY_EN
  assign out_parity = ^acc_q;
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_acc.sv
// logic_acc bench: directed steps then random ops
// against a behavioural accumulator model.
module tb_logic_acc;
  import logic_acc_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_data, out_acc;
  logic         out_valid, out_ready;
  logic         out_zero, out_parity;
  logic [3:0]   ops_done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_acc;
  bit           m_busy;
  int           m_ops;

  logic_acc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] apply(
    input logic [W-1:0] a,
    input logic [1:0]   op,
    input logic [W-1:0] b
  );
    if (op == 2'b00) return a ^ b;
    if (op == 2'b01) return a & b;
    if (op == 2'b10) return a | b;
    return b;
  endfunction

  function automatic bit par(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += v[i];
`ifdef LOGIC_ACC_PARITY_EN
    return bit'(n % 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 32'(!m_busy));
    chk({tag, "_vld"}, 32'(out_valid), 32'(m_busy));
    chk({tag, "_acc"}, 32'(out_acc), 32'(m_acc));
    chk({tag, "_zero"}, 32'(out_zero),
        32'(m_acc == 0));
    chk({tag, "_par"}, 32'(out_parity),
        32'(par(m_acc)));
    chk({tag, "_ops"}, 32'(ops_done),
        32'(m_ops % 16));
  endtask

  task automatic cyc(
    input string        tag,
    input bit           c,
    input bit           iv,
    input logic [1:0]   op,
    input logic [W-1:0] d,
    input bit           ordy
  );
    clr       = c;
    in_valid  = iv;
    in_op     = op;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    if (c) begin
      m_acc  = '0;
      m_busy = 0;
    end else if (!m_busy && iv) begin
      m_acc  = apply(m_acc, op, d);
      m_busy = 1;
    end else if (m_busy && ordy) begin
      m_busy = 0;
      m_ops  = (m_ops + 1) % 16;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic model_reset();
    m_acc  = '0;
    m_busy = 0;
    m_ops  = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("rst");
    chk("rst_zero_k", 32'(out_zero), 32'd1);
    rst_n = 1'b1;

    cyc("ld_a", 0, 1, OP_LOAD, 4'hA, 1);
    chk("ld_a_k", 32'(out_acc), 32'hA);
    chk("ld_a_vld_k", 32'(out_valid), 32'd1);
    cyc("ld_a_rel", 0, 0, OP_XOR, 4'h0, 1);
    chk("ld_a_ops_k", 32'(ops_done), 32'd1);

    cyc("xf", 0, 1, OP_XOR, 4'hF, 0);
    chk("xf_k", 32'(out_acc), 32'h5);
    cyc("xf_rel", 0, 0, OP_XOR, 4'h0, 1);
    cyc("a3", 0, 1, OP_AND, 4'h3, 1);
    chk("a3_k", 32'(out_acc), 32'h1);
    cyc("a3_rel", 0, 0, OP_XOR, 4'h0, 1);
    cyc("o8", 0, 1, OP_OR, 4'h8, 1);
    chk("o8_k", 32'(out_acc), 32'h9);
    cyc("o8_rel", 0, 0, OP_XOR, 4'h0, 1);
    chk("ops4_k", 32'(ops_done), 32'd4);

    cyc("ld5", 0, 1, OP_LOAD, 4'h5, 0);
    cyc("ld5_rel", 0, 0, OP_XOR, 4'h0, 1);
    cyc("x5", 0, 1, OP_XOR, 4'h5, 0);
    chk("x5_zero_k", 32'(out_zero), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc("hold", 0, 1, 2'($urandom_range(3)),
          W'($urandom), 0);
      chk("hold_acc_k", 32'(out_acc), 32'h0);
    end
    cyc("x5_rel", 0, 0, OP_XOR, 4'h0, 1);

    cyc("ld7", 0, 1, OP_LOAD, 4'h7, 0);
    cyc("clr_pri", 1, 1, OP_LOAD, 4'hF, 1);
    chk("clr_pri_acc_k", 32'(out_acc), 32'h0);
    chk("clr_pri_rdy_k", 32'(in_ready), 32'd1);
    chk("clr_pri_ops_k", 32'(ops_done), 32'd6);

    for (int i = 0; i < 16; i++) begin
      cyc("wrap_ld", 0, 1, OP_LOAD, W'(i), 0);
      cyc("wrap_rel", 0, 0, OP_XOR, 4'h0, 1);
    end
    chk("wrap_ops_k", 32'(ops_done), 32'd6);

    cyc("pre_rst", 0, 1, OP_LOAD, 4'hC, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    cyc("ld1", 0, 1, OP_LOAD, 4'h1, 0);
    chk("ld1_par_k", 32'(out_parity),
        32'(par(4'h1)));
    cyc("ld1_rel", 0, 0, OP_XOR, 4'h0, 1);

    for (int i = 0; i < 300; i++) begin
      cyc("rnd", ($urandom_range(15) == 0),
          1'($urandom), 2'($urandom_range(3)),
          W'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
